// File: rtl/btn_sw_conditioner_pkg.sv
// btn_sw_conditioner_pkg: button index map, default widths and debounce helpers
//   BTN_C/L/U/R/D : channel index of each board button on btn_raw/btn_level/btn_pulse
//   BTN_COUNT     : number of button channels
//   SW_WIDTH      : switch bus width
//   DEBOUNCE_10MS : stable-cycle count for 10 ms at 100 MHz
package btn_sw_conditioner_pkg;
    localparam int BTN_C         = 0;
    localparam int BTN_L         = 1;
    localparam int BTN_U         = 2;
    localparam int BTN_R         = 3;
    localparam int BTN_D         = 4;
    localparam int BTN_COUNT     = 5;
    localparam int SW_WIDTH      = 16;
    localparam int DEBOUNCE_10MS = 1000000;

    // Counter width that holds 0..cycles-1; never below one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 2) ? $clog2(cycles) : 1;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one button channel -- 2-flop sync, stability counter, level and rising pulse
//   clk       in  system clock
//   rst_n     in  synchronous reset, active low
//   btn_raw   in  asynchronous raw button
//   btn_level out debounced level
//   btn_pulse out one-cycle pulse when btn_level rises
module btn_debounce
    import btn_sw_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("btn_debounce: DEBOUNCE_CYCLES must be >= 2");
    end

    logic             r_s1;
    logic             r_s2;
    logic [CNT_W-1:0] r_cnt;

    // Any agreement between the synced input and the level restarts the window,
    // so a commit needs DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_cnt     <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            r_s1      <= btn_raw;
            r_s2      <= r_s1;
            btn_pulse <= 1'b0;
            if (r_s2 == btn_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                btn_level <= r_s2;
                btn_pulse <= r_s2;
                r_cnt     <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/btn_sw_conditioner.sv
// btn_sw_conditioner: synchronise switches, debounce buttons, emit press pulses
//   clk       in  system clock, all logic on posedge
//   rst_n     in  synchronous reset, active low
//   btn_raw   in  raw buttons [0]=C [1]=L [2]=U [3]=R [4]=D
//   sw_raw    in  raw switches
//   btn_level out debounced button levels
//   btn_pulse out one-cycle pulse per debounced press
//   sw_sync   out 2-flop synchronised switches (not debounced)
module btn_sw_conditioner
    import btn_sw_conditioner_pkg::*;
#(
    parameter int NUM_BTN         = BTN_COUNT,
    parameter int SW_W            = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [SW_W-1:0]    sw_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_pulse,
    output logic [SW_W-1:0]    sw_sync
);
    logic [SW_W-1:0] r_sw_s1;
    logic [SW_W-1:0] r_sw_s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sw_s1 <= '0;
            r_sw_s2 <= '0;
        end else begin
            r_sw_s1 <= sw_raw;
            r_sw_s2 <= r_sw_s1;
        end
    end

    assign sw_sync = r_sw_s2;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .btn_raw  (btn_raw[g]),
            .btn_level(btn_level[g]),
            .btn_pulse(btn_pulse[g])
        );
    end
endmodule

// File: tb/tb_btn_sw_conditioner.sv
// tb_btn_sw_conditioner: scenario tasks plus random traffic against a window-based reference model
module tb_btn_sw_conditioner;
    import btn_sw_conditioner_pkg::*;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  btn_raw = '0;
    logic [15:0] sw_raw = '0;
    logic [4:0]  btn_level, btn_pulse;
    logic [15:0] sw_sync;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: a button level flips once the last D synchronised samples
    // (taken since the last reset) all disagree with it.
    logic [4:0]  m_p1 = '0, m_p2 = '0, m_level = '0, m_pulse = '0;
    logic [15:0] m_sw1 = '0, m_sw2 = '0;
    logic [4:0]  hist[$];

    btn_sw_conditioner #(
        .NUM_BTN(5),
        .SW_W(16),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_raw  (btn_raw),
        .sw_raw   (sw_raw),
        .btn_level(btn_level),
        .btn_pulse(btn_pulse),
        .sw_sync  (sw_sync)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit flip;
        if (!rst_n) begin
            m_p1 = '0; m_p2 = '0; m_sw1 = '0; m_sw2 = '0;
            m_level = '0; m_pulse = '0;
            hist.delete();
        end else begin
            hist.push_back(m_p2);
            if (hist.size() > D) void'(hist.pop_front());
            m_pulse = '0;
            for (int c = 0; c < 5; c++) begin
                flip = (hist.size() == D);
                for (int k = 0; k < hist.size(); k++)
                    if (hist[k][c] == m_level[c]) flip = 1'b0;
                if (flip) begin
                    m_level[c] = ~m_level[c];
                    m_pulse[c] = m_level[c];
                end
            end
            m_p2 = m_p1; m_p1 = btn_raw;
            m_sw2 = m_sw1; m_sw1 = sw_raw;
        end
    endtask

    task automatic step(input logic r, input logic [4:0] b, input logic [15:0] s);
        @(negedge clk);
        rst_n = r; btn_raw = b; sw_raw = s;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        logic [4:0]  e_lv, e_p;
        logic [15:0] e_sw;
        for (int j = 0; j < 3; j++) begin
            step(1'b0, 5'h1F, 16'hFFFF);
            n_chk++;
            if ({btn_level, btn_pulse, sw_sync} !== 26'd0)
                $display("FAIL reset_hold: got lvl=%h pls=%h sw=%h want all 0", btn_level, btn_pulse, sw_sync);
            else n_pass++;
        end
        for (int j = 1; j <= 8; j++) begin
            step(1'b1, 5'h1F, 16'hFFFF);
            e_sw = (j >= 2) ? 16'hFFFF : 16'h0;
            e_lv = (j >= 6) ? 5'h1F : 5'h0;
            e_p  = (j == 6) ? 5'h1F : 5'h0;
            n_chk++;
            if ({btn_level, btn_pulse, sw_sync} !== {e_lv, e_p, e_sw})
                $display("FAIL reset_release edge %0d: got lvl=%h pls=%h sw=%h want lvl=%h pls=%h sw=%h",
                         j, btn_level, btn_pulse, sw_sync, e_lv, e_p, e_sw);
            else n_pass++;
        end
        for (int j = 0; j < 8; j++) step(1'b1, 5'h0, 16'h0);
    endtask

    task automatic test_clean_press();
        for (int j = 0; j < 20; j++) begin
            step(1'b1, 5'h10, 16'h0);
            n_chk++;
            if (btn_level[BTN_D] !== (j >= 5) || btn_pulse !== ((j == 5) ? 5'h10 : 5'h0) || btn_level[3:0] !== 4'h0)
                $display("FAIL press_D step %0d: got lvl=%h pls=%h", j, btn_level, btn_pulse);
            else n_pass++;
        end
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 5'h0, 16'h0);
            n_chk++;
            if (btn_level[BTN_D] !== (j < 5) || btn_pulse !== 5'h0)
                $display("FAIL release_D step %0d: got lvl=%h pls=%h", j, btn_level, btn_pulse);
            else n_pass++;
        end
    endtask

    task automatic test_glitch();
        bit seen = 1'b0;
        for (int j = 0; j < 14; j++) begin
            step(1'b1, (j < 3) ? 5'h01 : 5'h00, 16'h0);
            if (btn_level[BTN_C] || btn_pulse[BTN_C]) seen = 1'b1;
        end
        n_chk++;
        if (seen) $display("FAIL glitch_C: got level/pulse asserted want never");
        else n_pass++;
    endtask

    task automatic test_bounce();
        logic [6:0] pat = 7'b0111011;
        int pulses = 0;
        for (int j = 0; j < 25; j++) begin
            step(1'b1, {2'b0, (j < 7) ? pat[j] : 1'b1, 2'b0}, 16'h0);
            pulses += int'(btn_pulse[BTN_U]);
            n_chk++;
            if (btn_pulse[BTN_U] !== (j == 12) || btn_level[BTN_U] !== (j >= 12))
                $display("FAIL bounce_U step %0d: got lvl=%b pls=%b", j, btn_level[BTN_U], btn_pulse[BTN_U]);
            else n_pass++;
        end
        n_chk++;
        if (pulses != 1) $display("FAIL bounce_count: got %0d pulses want 1", pulses);
        else n_pass++;
        for (int j = 0; j < 8; j++) step(1'b1, 5'h0, 16'h0);
    endtask

    task automatic test_simultaneous();
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 5'b01010, 16'h1234);
            n_chk++;
            if (sw_sync !== ((j >= 1) ? 16'h1234 : 16'h0) ||
                btn_pulse !== ((j == 5) ? 5'b01010 : 5'b0) ||
                btn_level !== ((j >= 5) ? 5'b01010 : 5'b0))
                $display("FAIL simul step %0d: got lvl=%h pls=%h sw=%h", j, btn_level, btn_pulse, sw_sync);
            else n_pass++;
        end
        for (int j = 0; j < 8; j++) step(1'b1, 5'h0, 16'h0);
    endtask

    task automatic test_reset_mid_hold();
        for (int j = 0; j < 8; j++) step(1'b1, 5'h04, 16'hA5A5);
        n_chk++;
        if (btn_level !== 5'h04) $display("FAIL midhold_pre: got lvl=%h want 04", btn_level);
        else n_pass++;
        step(1'b0, 5'h04, 16'hA5A5);
        n_chk++;
        if ({btn_level, btn_pulse, sw_sync} !== 26'd0)
            $display("FAIL midhold_reset: got lvl=%h pls=%h sw=%h want 0", btn_level, btn_pulse, sw_sync);
        else n_pass++;
        for (int j = 0; j < 10; j++) begin
            step(1'b1, 5'h04, 16'hA5A5);
            n_chk++;
            if (btn_pulse !== ((j == 5) ? 5'h04 : 5'h0))
                $display("FAIL midhold_repress step %0d: got pls=%h", j, btn_pulse);
            else n_pass++;
        end
        for (int j = 0; j < 8; j++) step(1'b1, 5'h0, 16'h0);
    endtask

    task automatic test_random();
        logic [4:0] b = '0;
        for (int j = 0; j < 600; j++) begin
            for (int c = 0; c < 5; c++)
                if ($urandom_range(5) == 0) b[c] = ~b[c];
            step(($urandom_range(149) != 0), b, 16'($urandom));
            n_chk++;
            if ({btn_level, btn_pulse, sw_sync} !== {m_level, m_pulse, m_sw2})
                $display("FAIL random step %0d: got lvl=%h pls=%h sw=%h want lvl=%h pls=%h sw=%h",
                         j, btn_level, btn_pulse, sw_sync, m_level, m_pulse, m_sw2);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_bounce();
        test_simultaneous();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
